// File: rtl/hex_to_bcd_if.sv
// hex_to_bcd_if
//   Start/done handshake bundle for the sequential binary-to-BCD converter.
//   Signals:
//     start    - conversion request from the master, honoured only when idle
//     Hex      - 32-bit unsigned binary operand, captured on an accepted start
//     BCD      - packed 8-digit BCD result (digit 7 in [31:28])
//     busy     - conversion in progress
//     done     - one-cycle pulse when BCD/overflow update
//     overflow - last converted value exceeded 99,999,999
//   Modports:
//     master - the requester (drives start/Hex, observes results)
//     slave  - the converter (observes start/Hex, drives results)
interface hex_to_bcd_if;
  logic        start;
  logic [31:0] Hex;
  logic [31:0] BCD;
  logic        busy;
  logic        done;
  logic        overflow;

  modport master (
    output start,
    output Hex,
    input  BCD,
    input  busy,
    input  done,
    input  overflow
  );

  modport slave (
    input  start,
    input  Hex,
    output BCD,
    output busy,
    output done,
    output overflow
  );
endinterface

// File: rtl/hex_to_bcd.sv
// hex_to_bcd
//   Sequential 32-bit binary to 8-digit packed BCD converter using the
//   double-dabble (shift-and-add-3) algorithm, one input bit per clock.
//   A conversion takes 32 clocks from the accepting edge to the done pulse.
//   Values above 99,999,999 saturate to 9999_9999 with overflow set.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset; aborts any conversion in flight
//     bus   - hex_to_bcd_if.slave (start, Hex, BCD, busy, done, overflow)
module hex_to_bcd (
  input  logic          clk,
  input  logic          rst_n,
  hex_to_bcd_if.slave   bus
);

  localparam int DATA_W   = 32;           // binary operand width
  localparam int DIGITS   = 10;           // scratch digits (2^32 needs 10)
  localparam int SCR_W    = DIGITS * 4;   // scratch width
  localparam int OUT_DIG  = 8;            // digits presented on BCD
  localparam int CAT_W    = SCR_W + DATA_W;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [5:0] LAST_BIT = 6'(DATA_W - 1);

  // Add 3 to every scratch digit that is 5 or more, so that the following
  // left shift carries correctly into the next decimal digit.
  function automatic logic [SCR_W-1:0] dabble_adjust(input logic [SCR_W-1:0] scr);
    logic [SCR_W-1:0] res;
    logic [3:0]       dig;
    res = scr;
    for (int d = 0; d < DIGITS; d++) begin
      dig = scr[d*4 +: 4];
      if (dig >= 4'd5) begin
        res[d*4 +: 4] = dig + 4'd3;
      end
    end
    return res;
  endfunction

  // Clamp the 10-digit result to the 8-digit output range.
  // Returns {overflow, bcd}.
  function automatic logic [OUT_DIG*4:0] saturate(input logic [SCR_W-1:0] scr);
    logic [OUT_DIG*4:0] res;
    if (scr[SCR_W-1 -: 8] != 8'h00) begin
      res = {1'b1, 32'h9999_9999};
    end else begin
      res = {1'b0, scr[OUT_DIG*4-1:0]};
    end
    return res;
  endfunction

  logic [0:0]        state_q;
  logic [DATA_W-1:0] shift_q;
  logic [SCR_W-1:0]  scratch_q;
  logic [5:0]        cnt_q;
  logic [31:0]       bcd_q;
  logic              ovf_q;
  logic              done_q;

  logic [CAT_W-1:0]  cat_adj;
  logic [CAT_W-1:0]  cat_next;
  logic [SCR_W-1:0]  scratch_next;
  logic [DATA_W-1:0] shift_next;
  logic [32:0]       sat_res;
  logic              accept;
  logic              last_step;

  // Combinational double-dabble step: adjust, then shift one bit of the
  // binary operand into the scratch.
  always_comb begin
    cat_adj      = {dabble_adjust(scratch_q), shift_q};
    cat_next     = {cat_adj[CAT_W-2:0], 1'b0};
    scratch_next = cat_next[CAT_W-1 -: SCR_W];
    shift_next   = cat_next[DATA_W-1:0];
    sat_res      = saturate(scratch_next);
  end

  assign accept    = (state_q == ST_IDLE) && bus.start;
  assign last_step = (state_q == ST_RUN) && (cnt_q == LAST_BIT);

  // Control: idle/run state, bit counter, done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q + 6'd1;
          if (last_step) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Datapath: operand capture and iterative shift-and-add-3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      scratch_q <= '0;
    end else if (accept) begin
      shift_q   <= bus.Hex;
      scratch_q <= '0;
    end else if (state_q == ST_RUN) begin
      shift_q   <= shift_next;
      scratch_q <= scratch_next;
    end
  end

  // Result: loaded only from the final post-shift scratch, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (last_step) begin
      bcd_q <= sat_res[31:0];
      ovf_q <= sat_res[32];
    end
  end

  assign bus.BCD      = bcd_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state_q == ST_RUN);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_hex_to_bcd.sv
module tb_hex_to_bcd;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  hex_to_bcd_if bus ();

  hex_to_bcd dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a start pulse; returns #1 after the accepting edge.
  task automatic kick(input logic [31:0] val);
    @(negedge clk);
    bus.start = 1'b1;
    bus.Hex   = val;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Wait for done, returning the number of edges after the accepting edge
  // (-1 if it never came within the budget).
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.Hex   = 32'h0;
    #12;
    vectors++;
    if (bus.BCD !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
      $display("FAIL reset_outputs: BCD=%h busy=%b done=%b ovf=%b, want 0/0/0/0",
               bus.BCD, bus.busy, bus.done, bus.overflow);
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    kick(32'd12);
    vectors++;
    if (bus.busy !== 1'b1) begin
      $display("FAIL basic_busy_after_accept: busy=%b want 1", bus.busy);
      miscompares++;
    end
    wait_done(lat);
    vectors++;
    if (lat !== 32) begin
      $display("FAIL basic_latency: got %0d want 32", lat);
      miscompares++;
    end
    vectors++;
    if (bus.BCD !== 32'h0000_0012 || bus.overflow !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL basic_result: BCD=%h ovf=%b busy=%b, want 00000012/0/0",
               bus.BCD, bus.overflow, bus.busy);
      miscompares++;
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.done !== 1'b0 || bus.BCD !== 32'h0000_0012) begin
      $display("FAIL basic_done_single: done=%b BCD=%h, want 0/00000012", bus.done, bus.BCD);
      miscompares++;
    end
  endtask

  task automatic test_values();
    logic [31:0] hex_t [5];
    logic [31:0] bcd_t [5];
    logic        ovf_t [5];
    int          lat;
    hex_t[0] = 32'd0;          bcd_t[0] = 32'h0000_0000; ovf_t[0] = 1'b0;
    hex_t[1] = 32'd12345678;   bcd_t[1] = 32'h1234_5678; ovf_t[1] = 1'b0;
    hex_t[2] = 32'd99999999;   bcd_t[2] = 32'h9999_9999; ovf_t[2] = 1'b0;
    hex_t[3] = 32'd100000000;  bcd_t[3] = 32'h9999_9999; ovf_t[3] = 1'b1;
    hex_t[4] = 32'hFFFF_FFFF;  bcd_t[4] = 32'h9999_9999; ovf_t[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      kick(hex_t[i]);
      wait_done(lat);
      vectors++;
      if (lat !== 32) begin
        $display("FAIL value_latency[%0d]: got %0d want 32", i, lat);
        miscompares++;
      end
      vectors++;
      if (bus.BCD !== bcd_t[i] || bus.overflow !== ovf_t[i]) begin
        $display("FAIL value[%0d] hex=%0d: BCD=%h ovf=%b, want %h/%b",
                 i, hex_t[i], bus.BCD, bus.overflow, bcd_t[i], ovf_t[i]);
        miscompares++;
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    int dones;
    kick(32'd12);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.Hex   = 32'd555;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      $display("FAIL ignored_busy: busy=%b done=%b want 1/0", bus.busy, bus.done);
      miscompares++;
    end
    // 10 edges consumed after accept; done expected 22 edges later
    lat = -1;
    for (int i = 11; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    vectors++;
    if (lat !== 32) begin
      $display("FAIL ignored_latency: got %0d want 32", lat);
      miscompares++;
    end
    vectors++;
    if (bus.BCD !== 32'h0000_0012 || bus.overflow !== 1'b0) begin
      $display("FAIL ignored_result: BCD=%h ovf=%b want 00000012/0", bus.BCD, bus.overflow);
      miscompares++;
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      $display("FAIL ignored_no_second_conv: busy/done cycles=%0d want 0", dones);
      miscompares++;
    end
  endtask

  task automatic test_abort();
    int lat;
    int seen;
    kick(32'd87654321);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.BCD !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
      $display("FAIL abort_async_clear: BCD=%h busy=%b done=%b ovf=%b, want 0/0/0/0",
               bus.BCD, bus.busy, bus.done, bus.overflow);
      miscompares++;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      $display("FAIL abort_no_done: busy/done cycles=%0d want 0", seen);
      miscompares++;
    end
    kick(32'd42);
    wait_done(lat);
    vectors++;
    if (lat !== 32 || bus.BCD !== 32'h0000_0042 || bus.overflow !== 1'b0) begin
      $display("FAIL abort_restart: lat=%0d BCD=%h ovf=%b, want 32/00000042/0",
               lat, bus.BCD, bus.overflow);
      miscompares++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    kick(32'd7);
    wait_done(lat);
    vectors++;
    if (lat !== 32 || bus.BCD !== 32'h0000_0007 || bus.busy !== 1'b0) begin
      $display("FAIL b2b_first: lat=%0d BCD=%h busy=%b, want 32/00000007/0",
               lat, bus.BCD, bus.busy);
      miscompares++;
    end
    // Present the next start while done is high; accepted on the following edge.
    bus.start = 1'b1;
    bus.Hex   = 32'd98;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.BCD !== 32'h0000_0007) begin
      $display("FAIL b2b_accept: done=%b busy=%b BCD=%h, want 0/1/00000007",
               bus.done, bus.busy, bus.BCD);
      miscompares++;
    end
    wait_done(lat);
    vectors++;
    if (lat !== 32 || bus.BCD !== 32'h0000_0098 || bus.overflow !== 1'b0) begin
      $display("FAIL b2b_second: lat=%0d BCD=%h ovf=%b, want 32/00000098/0",
               lat, bus.BCD, bus.overflow);
      miscompares++;
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.done !== 1'b0) begin
      $display("FAIL b2b_done_single: done=%b want 0", bus.done);
      miscompares++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_values();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
